// File: rtl/serializer_pkg.sv
// Shared constants, state encoding and parity helper for the PISO serializer.
package serializer_pkg;

    localparam int WORD_W = 8;
    localparam int CNT_W  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] LSB_START = 3'd0;
    localparam logic [CNT_W-1:0] LSB_END   = 3'd7;
    localparam logic [CNT_W-1:0] MSB_START = 3'd7;
    localparam logic [CNT_W-1:0] MSB_END   = 3'd0;

    function automatic logic even_parity(input logic [WORD_W-1:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/mux8x1.sv
// 8:1 single-bit multiplexer used as the serializer's bit selector.
module mux8x1 (
    input  logic       i0,
    input  logic       i1,
    input  logic       i2,
    input  logic       i3,
    input  logic       i4,
    input  logic       i5,
    input  logic       i6,
    input  logic       i7,
    input  logic [2:0] s,
    output logic       res
);

    // select one of eight inputs
    always_comb begin
        res = 1'b0;
        case (s)
            3'd0:    res = i0;
            3'd1:    res = i1;
            3'd2:    res = i2;
            3'd3:    res = i3;
            3'd4:    res = i4;
            3'd5:    res = i5;
            3'd6:    res = i6;
            3'd7:    res = i7;
            default: res = 1'b0;
        endcase
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: captures a word and streams it bit-serially via mux8x1.
// Optional SERIALIZER_PARITY_EN appends an even-parity beat after the eighth data bit.
module piso_serializer
    import serializer_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [WORD_W-1:0] data_in,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_last,
    input  logic              ser_ready,
    output logic              busy
);

    localparam logic [CNT_W-1:0] START_IDX = LSB_FIRST ? LSB_START : MSB_START;
    localparam logic [CNT_W-1:0] END_IDX   = LSB_FIRST ? LSB_END   : MSB_END;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mux_res_s;
    logic              shift_s;
    logic              data_last_s;
    logic              last_s;
    logic              ser_bit_s;
    logic              xfer_s;
    logic              load_ready_s;
    logic              load_fire_s;

    mux8x1 u_mux (
        .i0  (word_q[0]),
        .i1  (word_q[1]),
        .i2  (word_q[2]),
        .i3  (word_q[3]),
        .i4  (word_q[4]),
        .i5  (word_q[5]),
        .i6  (word_q[6]),
        .i7  (word_q[7]),
        .s   (cnt_q),
        .res (mux_res_s)
    );

    assign shift_s     = (state_q == SHIFT);
    assign data_last_s = shift_s && (cnt_q == END_IDX);

`ifdef SERIALIZER_PARITY_EN
    logic par_beat_q, par_beat_d;
    logic parity_q, parity_d;

    assign last_s    = shift_s && par_beat_q;
    assign ser_bit_s = par_beat_q ? parity_q : mux_res_s;

    // parity is latched with the word; the extra beat follows the last data bit
    always_comb begin
        par_beat_d = par_beat_q;
        parity_d   = parity_q;
        if (load_fire_s) begin
            par_beat_d = 1'b0;
            parity_d   = even_parity(data_in);
        end else if (xfer_s && data_last_s && !par_beat_q) begin
            par_beat_d = 1'b1;
        end else if (xfer_s && par_beat_q) begin
            par_beat_d = 1'b0;
        end else begin
            par_beat_d = par_beat_q;
        end
    end

    // parity beat registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_beat_q <= 1'b0;
            parity_q   <= 1'b0;
        end else begin
            par_beat_q <= par_beat_d;
            parity_q   <= parity_d;
        end
    end
`else
    assign last_s    = data_last_s;
    assign ser_bit_s = mux_res_s;
`endif

    assign xfer_s       = shift_s && ser_ready;
    assign load_ready_s = !shift_s || (last_s && ser_ready);
    assign load_fire_s  = load_valid && load_ready_s;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state: a load on the final beat keeps us in SHIFT with no bubble
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = load_valid ? SHIFT : IDLE;
            SHIFT: begin
                if (xfer_s && last_s) begin
                    state_d = load_valid ? SHIFT : IDLE;
                end else begin
                    state_d = SHIFT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // word capture and select stepping; the counter is reloaded at every word boundary
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (load_fire_s) begin
            word_d = data_in;
            cnt_d  = START_IDX;
        end else if (xfer_s && !data_last_s) begin
            cnt_d = LSB_FIRST ? (cnt_q + 3'd1) : (cnt_q - 3'd1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    // output decode
    always_comb begin
        ser_valid  = shift_s;
        busy       = shift_s;
        ser_last   = last_s;
        ser_out    = ser_bit_s;
        load_ready = load_ready_s;
    end

endmodule
